uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clocks per bit period (50 MHz clk, 9600 baud).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-004 RX  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 clr_rdy  input  1  one-cycle pulse acknowledging the received byte.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rdy  output  1  byte available in rx_data.
REQ-008 frm_err  output  1  last byte had a stop bit sampled low.
REQ-009 ovr  output  1  byte completed while rdy was still set.

Function
REQ-010 RX shall pass through a two-flop synchronizer reset to 1; all logic uses the synchronized value (rx_s).
REQ-011 States shall be IDLE, START, DATA, STOP.
REQ-012 IDLE: a falling edge of rx_s (previous 1, current 0) is the detect cycle; go to START and load the baud counter for a half-bit wait.
REQ-013 Sample instants: start at detect+BAUD_DIV/2 cycles; data bit n (n=0..7) at detect+BAUD_DIV/2+(n+1)*BAUD_DIV; stop at detect+BAUD_DIV/2+9*BAUD_DIV. BAUD_DIV/2 uses integer division.
REQ-014 START: if rx_s samples 1 at the start instant (false start), return to IDLE with no output change; else go to DATA.
REQ-015 DATA: each sample shifts rx_s into an 8-bit shift register from the MSB end so bit 0 lands in rx_data[0]; an internal 4-bit bit counter tracks bits; after bit 7 go to STOP.
REQ-016 STOP: at the stop instant, rx_data loads the shift register on the next edge, frm_err loads ~rx_s, rdy is set, and the FSM returns to IDLE.
REQ-017 rdy shall rise on the clock edge after the stop sample cycle and remain high until clr_rdy.
REQ-018 rx_data and frm_err shall hold stable between byte completions.
REQ-019 On completion, ovr shall be set if rdy is 1 and clr_rdy is 0 in the stop sample cycle; rx_data is overwritten with the new byte.
REQ-020 clr_rdy shall clear rdy and ovr on the next edge; in the same cycle as a completion, the completion wins: rdy=1, ovr unchanged.
REQ-021 A start is detected only after rx_s has been 1 for at least one cycle after returning to IDLE. A line held low after a framing error shall not retrigger.
REQ-022 Baud counter width shall be clog2(BAUD_DIV)+1 bits; no wrap-around in any state; the counter is idle in IDLE.
REQ-023 clr_rdy outside the rdy=1 condition shall be harmless.
REQ-024 RX activity while rdy=1 shall be received normally; no backpressure.

Reset
REQ-025 When rst=1 at an edge, the block shall enter IDLE and drive rdy=0, frm_err=0, ovr=0, rx_data=8'h00.
REQ-026 Reset shall also set both synchronizer flops to 1, clear the baud counter, the bit counter and the shift register, and abort any frame in progress.
REQ-027 After rst deasserts, the first frame shall be accepted only from a fresh 1->0 edge of rx_s.

Verification
REQ-028 Scenario: RX sends 0xA5 with a valid stop bit -> rdy rises exactly 1 cycle after the stop sample; rx_data=8'hA5; frm_err=0; ovr=0.
REQ-029 Scenario: RX low for 1000 clks, then high -> false start; rdy stays 0 and the FSM is back in IDLE after the start instant.
REQ-030 Scenario: send 0x3C with the stop bit held low -> rdy=1, rx_data=8'h3C, frm_err=1; the line staying low causes no new frame.
REQ-031 Scenario: send 0x11, then 0x22 without clr_rdy -> rx_data=8'h22, ovr=1; then clr_rdy pulse -> rdy=0, ovr=0.
REQ-032 Scenario: clr_rdy asserted in the stop sample cycle of 0x7E while rdy=1 -> rdy=1, ovr=1, rx_data=8'h7E.
REQ-033 Scenario: rst pulsed mid-frame at data bit 4 -> all outputs 0; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a fixed integer clock-per-bit divider.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - synchronous active-high reset
//   RX       - asynchronous serial line, idle high
//   clr_rdy  - one-cycle acknowledge of the received byte; clears rdy and ovr
//   rx_data  - last received byte, held until the next byte completes
//   rdy      - a byte is available in rx_data
//   frm_err  - the last byte had its stop bit sampled low
//   ovr      - a byte completed while rdy was still set
//
// A falling edge on the synchronized line starts a half-bit wait to the middle of
// the start bit. After that the line is sampled once every BAUD_DIV cycles for the
// 8 data bits and the stop bit.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam int unsigned CntW = $clog2(BAUD_DIV) + 1;
    // Counter reload values; a sample is taken in the cycle where the counter reads zero.
    localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            armed_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            frm_err   <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            // A completion in the stop state below overrides this clear.
            if (clr_rdy) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    // armed_q remembers a high line during a previous idle cycle, so a
                    // line still low after a frame cannot look like a new start edge.
                    if (armed_q && !rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= HalfLoad;
                        armed_q <= 1'b0;
                    end else begin
                        armed_q <= rx_s;
                    end
                end

                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s) begin
                        // False start: glitch shorter than half a bit.
                        state_q <= StIdle;
                    end else begin
                        state_q <= StData;
                        cnt_q   <= FullLoad;
                    end
                end

                StData: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= FullLoad;
                        if (bit_cnt_q == 4'd7) begin
                            state_q   <= StStop;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end

                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rx_data <= shift_q;
                        frm_err <= ~rx_s;
                        rdy     <= 1'b1;
                        // An acknowledge in this same cycle leaves ovr as it was.
                        ovr     <= ovr | (rdy & ~clr_rdy);
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A small behavioural model tracks what rdy, ovr,
// rx_data and frm_err must read after each completed frame or acknowledge; frame
// timing is derived from the bit-period arithmetic of the line protocol.
module tb_uart_rx;

    localparam int unsigned B = 16;
    localparam int unsigned H = B / 2;
    // Negedge index (counted from the negedge driving the start bit) at which rdy
    // must first read high: 2 sync cycles + half bit + 9 bit periods + 1 register edge.
    localparam int DoneJ = 3 + H + 9 * B;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_line = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic       m_rdy  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;
    logic [7:0] m_data = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx_line),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    function automatic void model_complete(input logic [7:0] d, input logic stop,
                                           input logic clr_same);
        m_ovr  = m_ovr | (m_rdy & ~clr_same);
        m_rdy  = 1'b1;
        m_data = d;
        m_ferr = ~stop;
    endfunction

    function automatic void model_clear();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endfunction

    // Drives one 10-bit frame; optionally pulses clr_rdy in the stop sample cycle or
    // pulses rst at negedge index rst_at (>= 0), abandoning the frame afterwards.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input bit clr_stop,
                               input int rst_at, output logic rdy_pre, output logic rdy_post,
                               output logic [7:0] d_post, output logic ferr_post,
                               output logic ovr_post);
        logic [9:0] bits;
        bits      = {stop, d, 1'b0};
        rdy_pre   = 1'b0;
        rdy_post  = 1'b0;
        d_post    = 8'h00;
        ferr_post = 1'b0;
        ovr_post  = 1'b0;
        for (int j = 0; j < 10 * B; j++) begin
            @(negedge clk);
            if (rst_at >= 0 && j == rst_at + 1) begin
                rst     = 1'b0;
                rx_line = 1'b1;
                return;
            end
            if (rst_at >= 0 && j == rst_at) rst = 1'b1;
            if (j == DoneJ - 1) rdy_pre = rdy;
            if (j == DoneJ) begin
                rdy_post  = rdy;
                d_post    = rx_data;
                ferr_post = frm_err;
                ovr_post  = ovr;
            end
            clr_rdy = clr_stop && (j == DoneJ - 1);
            rx_line = bits[j/B];
        end
        clr_rdy = 1'b0;
    endtask

    task automatic idle_high(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_line = 1'b1;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        checks += 4;
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
        if (frm_err !== 1'b0) begin
            errors++; $display("FAIL reset_frm_err got %b want 0", frm_err);
        end
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        rst = 1'b0;
        idle_high(4);
    endtask

    task automatic test_basic();
        logic pre, post, fe, ov;
        logic [7:0] d;
        drive_frame(8'hA5, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'hA5, 1'b1, 1'b0);
        checks += 5;
        if (pre !== 1'b0) begin errors++; $display("FAIL basic_rdy_early got %b want 0", pre); end
        if (post !== 1'b1) begin errors++; $display("FAIL basic_rdy_rise got %b want 1", post); end
        if (d !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", d); end
        if (fe !== 1'b0) begin errors++; $display("FAIL basic_frm_err got %b want 0", fe); end
        if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b want 0", ov); end
        idle_high(B);
        pulse_clr();
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL basic_clr_rdy got %b want 0", rdy); end
    endtask

    task automatic test_false_start();
        logic pre, post, fe, ov;
        logic [7:0] d;
        // Glitch well below half a bit period.
        for (int i = 0; i < int'(H) - 4; i++) begin
            @(negedge clk);
            rx_line = 1'b0;
        end
        idle_high(12 * B);
        checks += 2;
        if (rdy !== 1'b0) begin errors++; $display("FAIL false_start_rdy got %b want 0", rdy); end
        if (rx_data !== m_data) begin
            errors++; $display("FAIL false_start_data got %h want %h", rx_data, m_data);
        end
        // The receiver must be idle again and catch the next frame on time.
        drive_frame(8'h96, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'h96, 1'b1, 1'b0);
        checks += 3;
        if (pre !== 1'b0) begin errors++; $display("FAIL fs_next_rdy_early got %b want 0", pre); end
        if (post !== 1'b1) begin errors++; $display("FAIL fs_next_rdy got %b want 1", post); end
        if (d !== 8'h96) begin errors++; $display("FAIL fs_next_data got %h want 96", d); end
        idle_high(B);
        pulse_clr();
    endtask

    task automatic test_frame_error();
        logic pre, post, fe, ov;
        logic [7:0] d;
        drive_frame(8'h3C, 1'b0, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'h3C, 1'b0, 1'b0);
        checks += 3;
        if (post !== 1'b1) begin errors++; $display("FAIL ferr_rdy got %b want 1", post); end
        if (d !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", d); end
        if (fe !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", fe); end
        // Line stays low: acknowledge, then make sure nothing new arrives.
        pulse_clr();
        repeat (25 * B) @(negedge clk);
        checks += 3;
        if (rdy !== 1'b0) begin errors++; $display("FAIL ferr_retrigger got %b want 0", rdy); end
        if (rx_data !== 8'h3C) begin
            errors++; $display("FAIL ferr_hold_data got %h want 3c", rx_data);
        end
        if (frm_err !== 1'b1) begin
            errors++; $display("FAIL ferr_hold_flag got %b want 1", frm_err);
        end
        idle_high(2 * B);
    endtask

    task automatic test_overrun();
        logic pre, post, fe, ov;
        logic [7:0] d;
        drive_frame(8'h11, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'h11, 1'b1, 1'b0);
        idle_high(B);
        drive_frame(8'h22, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'h22, 1'b1, 1'b0);
        checks += 3;
        if (d !== 8'h22) begin errors++; $display("FAIL ovr_data got %h want 22", d); end
        if (ov !== m_ovr) begin errors++; $display("FAIL ovr_flag got %b want %b", ov, m_ovr); end
        if (post !== 1'b1) begin errors++; $display("FAIL ovr_rdy got %b want 1", post); end
        idle_high(B);
        pulse_clr();
        checks += 2;
        if (rdy !== 1'b0) begin errors++; $display("FAIL ovr_clr_rdy got %b want 0", rdy); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr_ovr got %b want 0", ovr); end
    endtask

    task automatic test_clr_in_stop();
        logic pre, post, fe, ov;
        logic [7:0] d;
        for (int k = 0; k < 2; k++) begin
            drive_frame(8'($urandom), 1'b1, 1'b0, -1, pre, post, d, fe, ov);
            model_complete(d, 1'b1, 1'b0);
            idle_high(4);
        end
        drive_frame(8'h7E, 1'b1, 1'b1, -1, pre, post, d, fe, ov);
        model_complete(8'h7E, 1'b1, 1'b1);
        checks += 3;
        if (post !== 1'b1) begin errors++; $display("FAIL clrstop_rdy got %b want 1", post); end
        if (ov !== m_ovr) begin
            errors++; $display("FAIL clrstop_ovr got %b want %b", ov, m_ovr);
        end
        if (d !== 8'h7E) begin errors++; $display("FAIL clrstop_data got %h want 7e", d); end
        idle_high(B);
        pulse_clr();
    endtask

    task automatic test_clr_idle();
        pulse_clr();
        idle_high(3);
        checks += 3;
        if (rdy !== 1'b0) begin errors++; $display("FAIL clr_idle_rdy got %b want 0", rdy); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL clr_idle_ovr got %b want 0", ovr); end
        if (rx_data !== m_data) begin
            errors++; $display("FAIL clr_idle_data got %h want %h", rx_data, m_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic pre, post, fe, ov;
        logic [7:0] d;
        drive_frame(8'hC3, 1'b0, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'hC3, 1'b0, 1'b0);
        idle_high(B);
        // Reset lands in the middle of data bit 4 of this frame.
        drive_frame(8'hF0, 1'b1, 1'b0, 5 * B + H, pre, post, d, fe, ov);
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_data = 8'h00;
        idle_high(2);
        checks += 4;
        if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b want 0", rdy); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL midrst_ovr got %b want 0", ovr); end
        if (frm_err !== 1'b0) begin
            errors++; $display("FAIL midrst_frm_err got %b want 0", frm_err);
        end
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_data got %h want 00", rx_data);
        end
        idle_high(12 * B);
        drive_frame(8'h5A, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
        model_complete(8'h5A, 1'b1, 1'b0);
        checks += 5;
        if (pre !== 1'b0) begin errors++; $display("FAIL after_rst_early got %b want 0", pre); end
        if (post !== 1'b1) begin errors++; $display("FAIL after_rst_rdy got %b want 1", post); end
        if (d !== 8'h5A) begin errors++; $display("FAIL after_rst_data got %h want 5a", d); end
        if (fe !== 1'b0) begin errors++; $display("FAIL after_rst_ferr got %b want 0", fe); end
        if (ov !== 1'b0) begin errors++; $display("FAIL after_rst_ovr got %b want 0", ov); end
        idle_high(B);
        pulse_clr();
    endtask

    // Frames driven with no idle gap between stop bit and next start bit.
    task automatic test_back_to_back();
        logic pre, post, fe, ov;
        logic [7:0] d, want;
        for (int k = 0; k < 3; k++) begin
            want = 8'($urandom);
            drive_frame(want, 1'b1, 1'b0, -1, pre, post, d, fe, ov);
            checks += 4;
            if (pre !== m_rdy) begin
                errors++; $display("FAIL b2b_rdy_early[%0d] got %b want %b", k, pre, m_rdy);
            end
            model_complete(want, 1'b1, 1'b0);
            if (post !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b want 1", k, post); end
            if (d !== want) begin
                errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, d, want);
            end
            if (ov !== m_ovr) begin
                errors++; $display("FAIL b2b_ovr[%0d] got %b want %b", k, ov, m_ovr);
            end
        end
        idle_high(B);
        pulse_clr();
    endtask

    task automatic test_random();
        logic pre, post, fe, ov;
        logic [7:0] d, want;
        logic stop;
        bit clr_stop, do_clr;
        int gap;
        for (int k = 0; k < 20; k++) begin
            want     = 8'($urandom);
            stop     = ($urandom_range(3) != 0);
            clr_stop = ($urandom_range(3) == 0);
            drive_frame(want, stop, clr_stop, -1, pre, post, d, fe, ov);
            checks += 5;
            if (pre !== m_rdy) begin
                errors++; $display("FAIL rnd_rdy_early[%0d] got %b want %b", k, pre, m_rdy);
            end
            model_complete(want, stop, clr_stop);
            if (post !== 1'b1) begin errors++; $display("FAIL rnd_rdy[%0d] got %b want 1", k, post); end
            if (d !== want) begin
                errors++; $display("FAIL rnd_data[%0d] got %h want %h", k, d, want);
            end
            if (fe !== m_ferr) begin
                errors++; $display("FAIL rnd_ferr[%0d] got %b want %b", k, fe, m_ferr);
            end
            if (ov !== m_ovr) begin
                errors++; $display("FAIL rnd_ovr[%0d] got %b want %b", k, ov, m_ovr);
            end
            gap    = stop ? int'($urandom_range(B)) : 3 + int'($urandom_range(B));
            do_clr = (gap >= 2) && ($urandom_range(2) == 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                rx_line = 1'b1;
                clr_rdy = do_clr && (g == 0);
            end
            clr_rdy = 1'b0;
            if (do_clr) model_clear();
        end
        idle_high(B);
        checks += 2;
        if (rdy !== m_rdy) begin errors++; $display("FAIL rnd_end_rdy got %b want %b", rdy, m_rdy); end
        if (ovr !== m_ovr) begin errors++; $display("FAIL rnd_end_ovr got %b want %b", ovr, m_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_clr_in_stop();
        test_clr_idle();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
